// File: rtl/idex_hazard_ctrl.sv
// idex_hazard_ctrl: stall/flush sequencer for the ID/EX pipeline register
module idex_hazard_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CW         = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_NeedRsByEX,
  input  logic        ID_NeedRtByEX,
  input  logic        ID_HiLoAccess,
  input  logic [4:0]  EX_WriteReg,
  input  logic        EX_RegWrite,
  input  logic        EX_MemRead,
  input  logic        EX_DivStart,
  input  logic        M_Stall,
  input  logic        Exc_Flush,
  output logic        ID_Stall,
  output logic        EX_Stall,
  output logic        ID_Flush,
  output logic        Div_Busy,
  output logic        Div_Done,
  output logic [15:0] Stall_Count
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DIV   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [CW-1:0] r_cnt;
  logic          r_div_done;
  logic [15:0]   r_stall_cnt;
  logic          w_busy;
  logic          w_cnt_zero;
  logic          w_accept;
  logic          w_lu;
  logic          w_hl;
  // next state, hazard detection and reset-gated stall/flush outputs
  always_comb begin
    w_busy     = r_state == S_DIV;
    w_cnt_zero = r_cnt == '0;
    w_accept   = (r_state == S_IDLE) & EX_DivStart & ~M_Stall;
    w_next     = Exc_Flush ? S_FLUSH : (w_accept | (w_busy & ~w_cnt_zero)) ? S_DIV : S_IDLE;
    w_lu       = EX_MemRead & EX_RegWrite & (EX_WriteReg != 5'd0) &
                 ((ID_NeedRsByEX & (ID_Rs == EX_WriteReg)) | (ID_NeedRtByEX & (ID_Rt == EX_WriteReg)));
    w_hl       = w_busy & ID_HiLoAccess;
    ID_Flush   = ~reset & (Exc_Flush | (r_state == S_FLUSH));
    EX_Stall   = ~reset & (M_Stall | (w_busy & EX_DivStart));
    ID_Stall   = ~reset & (EX_Stall | ((w_lu | w_hl) & ~ID_Flush));
    Div_Busy   = ~reset & w_busy;
  end
  // divider occupancy FSM; the counter loads on accept and runs down while busy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_div_done <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= (w_accept & ~Exc_Flush) ? CW'(DIV_CYCLES - 1) : w_busy ? r_cnt - 1'b1 : r_cnt;
      r_div_done <= w_busy & w_cnt_zero & ~Exc_Flush;
    end
  end
  // saturating count of stalled decode cycles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_stall_cnt <= '0;
    else if (ID_Stall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
  end
  assign Div_Done    = r_div_done;
  assign Stall_Count = r_stall_cnt;
endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// tb_idex_hazard_ctrl: scoreboard bench for the ID/EX stall/flush sequencer
module tb_idex_hazard_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  ID_Rs, ID_Rt, EX_WriteReg;
  logic        ID_NeedRsByEX, ID_NeedRtByEX, ID_HiLoAccess;
  logic        EX_RegWrite, EX_MemRead, EX_DivStart, M_Stall, Exc_Flush;
  logic        ID_Stall, EX_Stall, ID_Flush, Div_Busy, Div_Done;
  logic [15:0] Stall_Count;
  int n_chk = 0;
  int n_pass = 0;
  int m_state, m_cnt, m_sc;
  bit m_done;
  logic [20:0] q[$];
  logic l_ids, l_exs, l_idf, l_busy, l_done;
  logic [15:0] l_sc;
  always #5 clock = ~clock;
  idex_hazard_ctrl dut (
    .clock(clock), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_NeedRsByEX(ID_NeedRsByEX), .ID_NeedRtByEX(ID_NeedRtByEX), .ID_HiLoAccess(ID_HiLoAccess),
    .EX_WriteReg(EX_WriteReg), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
    .EX_DivStart(EX_DivStart), .M_Stall(M_Stall), .Exc_Flush(Exc_Flush),
    .ID_Stall(ID_Stall), .EX_Stall(EX_Stall), .ID_Flush(ID_Flush), .Div_Busy(Div_Busy),
    .Div_Done(Div_Done), .Stall_Count(Stall_Count)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, act, exp);
  endtask
  function automatic logic [20:0] model_out();
    bit busy, flush, exs, lu, ids;
    if (reset) return '0;
    busy  = m_state == 1;
    flush = Exc_Flush || m_state == 2;
    exs   = M_Stall || (busy && EX_DivStart);
    lu    = EX_MemRead && EX_RegWrite && EX_WriteReg != 0 &&
            ((ID_NeedRsByEX && ID_Rs == EX_WriteReg) || (ID_NeedRtByEX && ID_Rt == EX_WriteReg));
    ids   = exs || ((lu || (busy && ID_HiLoAccess)) && !flush);
    return {ids, exs, flush, busy, m_done, 16'(m_sc)};
  endfunction
  task automatic model_edge(input logic [20:0] o);
    bit busy;
    busy = m_state == 1;
    if (reset) begin
      m_state = 0; m_cnt = 0; m_done = 0; m_sc = 0;
      return;
    end
    if (o[20] && m_sc < 65535) m_sc++;
    m_done = busy && m_cnt == 0 && !Exc_Flush;
    if (Exc_Flush) m_state = 2;
    else if (m_state == 0 && EX_DivStart && !M_Stall) begin m_state = 1; m_cnt = 31; end
    else if (busy && m_cnt != 0) m_cnt--;
    else m_state = 0;
  endtask
  task automatic step();
    logic [20:0] e, g;
    e = model_out();
    q.push_back(e);
    #1;
    {l_ids, l_exs, l_idf, l_busy, l_done, l_sc} = {ID_Stall, EX_Stall, ID_Flush, Div_Busy, Div_Done, Stall_Count};
    g = {l_ids, l_exs, l_idf, l_busy, l_done, l_sc};
    chk("sb", 32'(g), 32'(q.pop_front()));
    @(posedge clock);
    model_edge(e);
    @(negedge clock);
  endtask
  task automatic idle_in();
    {ID_Rs, ID_Rt, EX_WriteReg} = '0;
    {ID_NeedRsByEX, ID_NeedRtByEX, ID_HiLoAccess, EX_RegWrite, EX_MemRead} = '0;
    {EX_DivStart, M_Stall, Exc_Flush} = '0;
  endtask
  task automatic load_use(input logic [4:0] wr);
    EX_MemRead = 1; EX_RegWrite = 1; EX_WriteReg = wr; ID_Rs = 5'd5; ID_NeedRsByEX = 1;
  endtask
  initial begin
    int busy_n, done_at, done_n, exs_n;
    logic [15:0] sc0;
    reset = 1'b1;
    idle_in();
    m_state = 0; m_cnt = 0; m_done = 0; m_sc = 0;
    @(negedge clock);
    step();
    chk("rst_sc", 32'(Stall_Count), 32'd0);
    reset = 1'b0;
    step();
    sc0 = Stall_Count;
    load_use(5'd5);
    step();
    chk("lu_id", 32'(l_ids), 32'd1);
    chk("lu_ex", 32'(l_exs), 32'd0);
    idle_in();
    step();
    chk("lu_sc", 32'(l_sc), 32'(sc0 + 16'd1));
    load_use(5'd0);
    step();
    chk("lu_r0", 32'(l_ids), 32'd0);
    ID_Rt = 5'd9; ID_NeedRtByEX = 1; ID_NeedRsByEX = 0; EX_WriteReg = 5'd9;
    step();
    chk("lu_rt", 32'(l_ids), 32'd1);
    idle_in();
    EX_DivStart = 1;
    step();
    EX_DivStart = 0;
    busy_n = 0; done_at = 0; done_n = 0;
    for (int i = 1; i <= 40; i++) begin
      ID_HiLoAccess = 1;
      step();
      if (l_busy) busy_n++;
      if (l_busy) chk("hl_busy", 32'(l_ids), 32'd1);
      if (l_done) begin done_at = i; done_n++; chk("hl_done", 32'(l_ids), 32'd0); end
    end
    chk("div_busy_n", 32'(busy_n), 32'd32);
    chk("div_done_at", 32'(done_at), 32'd33);
    chk("div_done_n", 32'(done_n), 32'd1);
    idle_in();
    EX_DivStart = 1;
    step();
    exs_n = 0;
    for (int i = 1; i <= 32; i++) begin
      step();
      if (l_exs) exs_n++;
    end
    chk("b2b_exs", 32'(exs_n), 32'd32);
    step();
    chk("b2b_gap", 32'({l_busy, l_exs}), 32'd0);
    EX_DivStart = 0;
    step();
    chk("b2b_2nd", 32'(l_busy), 32'd1);
    for (int i = 0; i < 21; i++) step();
    Exc_Flush = 1;
    load_use(5'd5);
    step();
    chk("exc_flush", 32'(l_idf), 32'd1);
    chk("exc_lu", 32'(l_ids), 32'd0);
    idle_in();
    step();
    chk("exc_fl2", 32'({l_idf, l_busy}), 32'b10);
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (l_done) done_n++;
    end
    chk("exc_nodone", 32'(done_n), 32'd0);
    M_Stall = 1;
    exs_n = 0;
    for (int i = 0; i < 70000; i++) begin
      step();
      if (!(l_exs && l_ids)) exs_n++;
    end
    chk("bp_stall", 32'(exs_n), 32'd0);
    chk("bp_sat", 32'(Stall_Count), 32'hFFFF);
    idle_in();
    EX_DivStart = 1;
    step();
    EX_DivStart = 0;
    for (int i = 0; i < 5; i++) step();
    M_Stall = 1; Exc_Flush = 1; ID_HiLoAccess = 1;
    #2 reset = 1'b1;
    #1;
    chk("arst_out", 32'({ID_Stall, EX_Stall, ID_Flush, Div_Busy, Div_Done}), 32'd0);
    chk("arst_sc", 32'(Stall_Count), 32'd0);
    @(posedge clock);
    model_edge('0);
    @(negedge clock);
    reset = 1'b0;
    idle_in();
    step();
    chk("arst_idle", 32'({l_busy, l_done, l_sc}), 32'd0);
    EX_DivStart = 1;
    step();
    EX_DivStart = 0;
    step();
    chk("arst_resume", 32'(l_busy), 32'd1);
    for (int i = 0; i < 35; i++) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
